// File: rtl/bus_decoder_if.sv
// Host/device handshake bundle for bus_decoder. The slave modport is the decoder's
// view; the master modport drives the host request and the device responses.
interface bus_decoder_if #(
    parameter int SIZE      = 2,
    parameter int BUS_WIDTH = 32
);
    logic                 host_req;
    logic [BUS_WIDTH-1:0] host_addr;
    logic                 host_gnt;
    logic                 host_rvalid;
    logic                 host_err;
    logic [SIZE-1:0]      dev_req;
    logic [SIZE-1:0]      dev_gnt;
    logic [SIZE-1:0]      dev_rvalid;
    logic [SIZE-1:0]      selector;
    logic                 busy;

    modport slave (
        input  host_req, host_addr, dev_gnt, dev_rvalid,
        output host_gnt, host_rvalid, host_err, dev_req, selector, busy
    );

    modport master (
        output host_req, host_addr, dev_gnt, dev_rvalid,
        input  host_gnt, host_rvalid, host_err, dev_req, selector, busy
    );
endinterface

// File: rtl/bus_decoder.sv
// Address decoder and single-outstanding response tracker for the peripheral bus.
// Define BUS_DECODER_TIMEOUT_EN to add a response timeout that returns an error.
module bus_decoder #(
    parameter int                             SIZE           = 2,
    parameter int                             BUS_WIDTH      = 32,
    parameter logic [SIZE-1:0][BUS_WIDTH-1:0] DEV_BASE       = {32'h8000_0000, 32'h0000_0000},
    parameter logic [SIZE-1:0][BUS_WIDTH-1:0] DEV_MASK       = {32'hFFFF_0000, 32'hFFF0_0000},
    parameter int                             TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    bus_decoder_if.slave       bus
);
    localparam int SEL_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSP  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [SEL_W-1:0]   sel_reg;
    logic [SIZE-1:0]    hit;
    logic [SEL_W-1:0]   hit_idx;
    logic               any_hit;
    logic               rsp_valid;
    logic               timeout;

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_hit
            assign hit[gi] = (bus.host_addr & DEV_MASK[gi]) == DEV_BASE[gi];
        end
        if (TIMEOUT_CYCLES < 1) begin : g_timeout_unset
        end
    endgenerate

    // Walk from the top so the lowest-index hit is the one left standing.
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            if (hit[k]) begin
                hit_idx = SEL_W'(k);
                any_hit = 1'b1;
            end
        end
    end

    assign rsp_valid = (state_reg == RSP) && bus.dev_rvalid[sel_reg];

`ifdef BUS_DECODER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg != RSP) begin
            cnt_reg <= '0;
        end else if (!rsp_valid) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // A response arriving in the expiry cycle takes precedence over the error.
    assign timeout = (state_reg == RSP) && !rsp_valid && (cnt_reg == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.host_req && any_hit && bus.dev_gnt[hit_idx]) begin
                sel_reg <= hit_idx;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.host_req) begin
                    if (!any_hit) begin
                        state_next = ERR;
                    end else if (bus.dev_gnt[hit_idx]) begin
                        state_next = RSP;
                    end
                end
            end
            RSP: begin
                if (rsp_valid || timeout) begin
                    state_next = IDLE;
                end
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Everything is held quiet while rst is high, including the cycle it is sampled.
    always_comb begin
        bus.dev_req     = '0;
        bus.host_gnt    = 1'b0;
        bus.host_rvalid = 1'b0;
        bus.host_err    = 1'b0;
        bus.selector    = '0;
        bus.busy        = 1'b0;
        if (!rst) begin
            bus.busy = (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (bus.host_req) begin
                        if (any_hit) begin
                            bus.dev_req[hit_idx] = 1'b1;
                            bus.host_gnt         = bus.dev_gnt[hit_idx];
                        end else begin
                            bus.host_gnt = 1'b1;
                        end
                    end
                end
                RSP: begin
                    bus.selector[sel_reg] = 1'b1;
                    bus.host_rvalid       = rsp_valid || timeout;
                    bus.host_err          = timeout;
                end
                ERR: begin
                    bus.host_rvalid = 1'b1;
                    bus.host_err    = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
